// File: rtl/sc_datapath_regbank_pkg.sv
// sc_datapath_pkg: shared encodings for the SC_STATEMACHINE datapath slice.
//   - BUSA/BUSB/debug mux select codes
//   - write-decoder "no write" code
//   - ALU opcodes
//   - shifter select codes
//   - bit positions of the flag vector
package sc_datapath_pkg;

  // Mux select codes; 110 and 111 both read zero.
  localparam logic [2:0] SEL_GEN0 = 3'b000;
  localparam logic [2:0] SEL_GEN1 = 3'b001;
  localparam logic [2:0] SEL_GEN2 = 3'b010;
  localparam logic [2:0] SEL_GEN3 = 3'b011;
  localparam logic [2:0] SEL_FIX0 = 3'b100;
  localparam logic [2:0] SEL_FIX1 = 3'b101;
  localparam logic [2:0] SEL_ZERO = 3'b110;

  // Any decoder value with the MSB set suppresses the write.
  localparam logic [2:0] DEC_NOWRITE = 3'b100;

  // ALU opcodes; unlisted codes pass A through.
  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_NOT  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_INC  = 4'b1010;
  localparam logic [3:0] ALU_DEC  = 4'b1011;

  // Shifter select codes; 11 also holds.
  localparam logic [1:0] SHIFT_HOLD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // Flag vector bit positions.
  localparam int unsigned FLAG_OV  = 0;
  localparam int unsigned FLAG_CY  = 1;
  localparam int unsigned FLAG_NEG = 2;
  localparam int unsigned FLAG_Z   = 3;

endpackage

// File: rtl/sc_datapath_regbank_if.sv
// sc_datapath_regbank_if: microinstruction / flag interface between the
// SC_STATEMACHINE (master) and the datapath register bank (slave).
//   master drives: decoder/mux/ALU/shifter selects, debug select
//   slave  drives: active-low flags, BUSC_Out, DebugData_Out
interface sc_datapath_regbank_if #(
  parameter int unsigned DATAWIDTH_BUS                 = 8,
  parameter int unsigned DATAWIDTH_DECODER_SELECTION   = 3,
  parameter int unsigned DATAWIDTH_MUX_SELECTION       = 3,
  parameter int unsigned DATAWIDTH_ALU_SELECTION       = 4,
  parameter int unsigned DATAWIDTH_REGSHIFTER_SELECTION = 2
);
  logic [DATAWIDTH_DECODER_SELECTION-1:0]    DecoderSelectionWrite_In;
  logic [DATAWIDTH_MUX_SELECTION-1:0]        MUXSelectionBUSA_In;
  logic [DATAWIDTH_MUX_SELECTION-1:0]        MUXSelectionBUSB_In;
  logic [DATAWIDTH_ALU_SELECTION-1:0]        ALUSelection_In;
  logic                                      RegSHIFTERLoad_InLow;
  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] RegSHIFTERShiftSelection_InLow;
  logic [DATAWIDTH_MUX_SELECTION-1:0]        DebugSelect_In;
  logic                                      Overflow_OutLow;
  logic                                      Carry_OutLow;
  logic                                      Negative_OutLow;
  logic                                      Zero_OutLow;
  logic [DATAWIDTH_BUS-1:0]                  BUSC_Out;
  logic [DATAWIDTH_BUS-1:0]                  DebugData_Out;

  modport master (
    output DecoderSelectionWrite_In, MUXSelectionBUSA_In, MUXSelectionBUSB_In,
           ALUSelection_In, RegSHIFTERLoad_InLow, RegSHIFTERShiftSelection_InLow,
           DebugSelect_In,
    input  Overflow_OutLow, Carry_OutLow, Negative_OutLow, Zero_OutLow,
           BUSC_Out, DebugData_Out
  );

  modport slave (
    input  DecoderSelectionWrite_In, MUXSelectionBUSA_In, MUXSelectionBUSB_In,
           ALUSelection_In, RegSHIFTERLoad_InLow, RegSHIFTERShiftSelection_InLow,
           DebugSelect_In,
    output Overflow_OutLow, Carry_OutLow, Negative_OutLow, Zero_OutLow,
           BUSC_Out, DebugData_Out
  );
endinterface

// File: rtl/sc_datapath_regbank_regshifter.sv
// sc_regshifter: load/shift register (RegSHIFTER) whose contents form BUSC.
//   clk, rst      : rising-edge clock, asynchronous active-high reset (-> 0)
//   load_n        : 0 loads din; has priority over shifting
//   shift_sel     : 01 shift left, 10 shift right (zero fill), else hold
//   q             : register contents
//   shift_out     : bit leaving the register on the current shift
//   shifting      : a shift (not a load) happens at the next edge
module sc_regshifter
  import sc_datapath_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SEL_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_n,
  input  logic [SEL_WIDTH-1:0] shift_sel,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     q,
  output logic                 shift_out,
  output logic                 shifting
);
  logic [WIDTH-1:0] sh_q, sh_d;

  always_comb begin
    sh_d      = sh_q;
    shift_out = 1'b0;
    shifting  = 1'b0;
    if (!load_n) begin
      sh_d = din;
    end else if (shift_sel == SEL_WIDTH'(SHIFT_LEFT)) begin
      sh_d      = {sh_q[WIDTH-2:0], 1'b0};
      shift_out = sh_q[WIDTH-1];
      shifting  = 1'b1;
    end else if (shift_sel == SEL_WIDTH'(SHIFT_RIGHT)) begin
      sh_d      = {1'b0, sh_q[WIDTH-1:1]};
      shift_out = sh_q[0];
      shifting  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign q = sh_q;
endmodule

// File: rtl/sc_datapath_regbank.sv
// sc_datapath_regbank: datapath slave of SC_STATEMACHINE.
//   SC_STATEMACHINE_CLOCK_50     : rising-edge clock
//   SC_STATEMACHINE_Reset_InHigh : asynchronous active-high reset
//   bus (slave modport)          : microinstruction selects in; active-low
//                                  flags, BUSC_Out and DebugData_Out out
// GEN0..3 are written only from BUSC (the shifter). FIX0/FIX1 are constants.
// BUSA/BUSB/ALU/debug read are combinational; flags are registered on loads.
// Optional: define SC_DATAPATH_SHIFT_CARRY_EN to capture the shifted-out bit
// into the carry flag on shift edges.
module sc_datapath_regbank
  import sc_datapath_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS                  = 8,
  parameter int unsigned DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int unsigned DATAWIDTH_MUX_SELECTION        = 3,
  parameter int unsigned DATAWIDTH_ALU_SELECTION        = 4,
  parameter int unsigned DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter logic [DATAWIDTH_BUS-1:0] FIX0_VALUE = 8'h01,
  parameter logic [DATAWIDTH_BUS-1:0] FIX1_VALUE = 8'h55
) (
  input logic                    SC_STATEMACHINE_CLOCK_50,
  input logic                    SC_STATEMACHINE_Reset_InHigh,
  sc_datapath_regbank_if.slave   bus
);
  localparam int unsigned DW  = DATAWIDTH_BUS;
  localparam int unsigned MSW = DATAWIDTH_MUX_SELECTION;
  localparam int unsigned AW  = DATAWIDTH_ALU_SELECTION;
  localparam int unsigned DCW = DATAWIDTH_DECODER_SELECTION;

  logic [DW-1:0] gen_q [4];
  logic [DW-1:0] gen_d [4];
  logic [3:0]    flag_n_q, flag_n_d;
  logic [DW-1:0] busa, busb, busc;
  logic [DW-1:0] alu_res;
  logic [DW:0]   arith;
  logic          alu_cy, alu_ov;
  logic          shift_out, shifting;

  function automatic logic [DW-1:0] bus_mux(input logic [MSW-1:0] sel,
                                            input logic [DW-1:0]  g [4]);
    logic [DW-1:0] v;
    case (sel)
      MSW'(SEL_GEN0): v = g[0];
      MSW'(SEL_GEN1): v = g[1];
      MSW'(SEL_GEN2): v = g[2];
      MSW'(SEL_GEN3): v = g[3];
      MSW'(SEL_FIX0): v = FIX0_VALUE;
      MSW'(SEL_FIX1): v = FIX1_VALUE;
      default:        v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    busa = bus_mux(bus.MUXSelectionBUSA_In, gen_q);
    busb = bus_mux(bus.MUXSelectionBUSB_In, gen_q);
  end

  // Arithmetic is done one bit wider; the top bit is carry for add and
  // borrow for subtract.
  always_comb begin
    arith   = '0;
    alu_res = busa;
    alu_cy  = 1'b0;
    alu_ov  = 1'b0;
    case (bus.ALUSelection_In)
      AW'(ALU_OR):  alu_res = busa | busb;
      AW'(ALU_AND): alu_res = busa & busb;
      AW'(ALU_NOT): alu_res = ~busa;
      AW'(ALU_XOR): alu_res = busa ^ busb;
      AW'(ALU_ADD): begin
        arith   = {1'b0, busa} + {1'b0, busb};
        alu_res = arith[DW-1:0];
        alu_cy  = arith[DW];
        alu_ov  = (busa[DW-1] == busb[DW-1]) && (alu_res[DW-1] != busa[DW-1]);
      end
      AW'(ALU_SUB): begin
        arith   = {1'b0, busa} - {1'b0, busb};
        alu_res = arith[DW-1:0];
        alu_cy  = arith[DW];
        alu_ov  = (busa[DW-1] != busb[DW-1]) && (alu_res[DW-1] != busa[DW-1]);
      end
      AW'(ALU_INC): begin
        arith   = {1'b0, busa} + (DW+1)'(1);
        alu_res = arith[DW-1:0];
        alu_cy  = arith[DW];
        alu_ov  = !busa[DW-1] && alu_res[DW-1];
      end
      AW'(ALU_DEC): begin
        arith   = {1'b0, busa} - (DW+1)'(1);
        alu_res = arith[DW-1:0];
        alu_cy  = arith[DW];
        alu_ov  = busa[DW-1] && !alu_res[DW-1];
      end
      default: ;
    endcase
  end

  sc_regshifter #(
    .WIDTH     (DW),
    .SEL_WIDTH (DATAWIDTH_REGSHIFTER_SELECTION)
  ) u_regshifter (
    .clk       (SC_STATEMACHINE_CLOCK_50),
    .rst       (SC_STATEMACHINE_Reset_InHigh),
    .load_n    (bus.RegSHIFTERLoad_InLow),
    .shift_sel (bus.RegSHIFTERShiftSelection_InLow),
    .din       (alu_res),
    .q         (busc),
    .shift_out (shift_out),
    .shifting  (shifting)
  );

  // Writes take the pre-edge BUSC, so a simultaneous load/shift never
  // affects the value written.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      gen_d[i] = gen_q[i];
      if (bus.DecoderSelectionWrite_In == DCW'(i)) gen_d[i] = busc;
    end
  end

  always_comb begin
    flag_n_d = flag_n_q;
    if (!bus.RegSHIFTERLoad_InLow) begin
      flag_n_d[FLAG_OV]  = ~alu_ov;
      flag_n_d[FLAG_CY]  = ~alu_cy;
      flag_n_d[FLAG_NEG] = ~alu_res[DW-1];
      flag_n_d[FLAG_Z]   = ~(alu_res == '0);
`ifdef SC_DATAPATH_SHIFT_CARRY_EN
    end else if (shifting) begin
      flag_n_d[FLAG_CY]  = ~shift_out;
`endif
    end
  end

`ifndef SC_DATAPATH_SHIFT_CARRY_EN
  logic unused_shift_info;
  assign unused_shift_info = shift_out ^ shifting;
`endif

  always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_Reset_InHigh) begin
    if (SC_STATEMACHINE_Reset_InHigh) begin
      for (int unsigned i = 0; i < 4; i++) gen_q[i] <= '0;
      flag_n_q <= '1;
    end else begin
      for (int unsigned i = 0; i < 4; i++) gen_q[i] <= gen_d[i];
      flag_n_q <= flag_n_d;
    end
  end

  assign bus.BUSC_Out        = busc;
  assign bus.Overflow_OutLow = flag_n_q[FLAG_OV];
  assign bus.Carry_OutLow    = flag_n_q[FLAG_CY];
  assign bus.Negative_OutLow = flag_n_q[FLAG_NEG];
  assign bus.Zero_OutLow     = flag_n_q[FLAG_Z];
  assign bus.DebugData_Out   = bus_mux(bus.DebugSelect_In, gen_q);
endmodule

// File: tb/tb_sc_datapath_regbank.sv
module tb_sc_datapath_regbank;
  import sc_datapath_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  sc_datapath_regbank_if bus ();

  sc_datapath_regbank #(
    .DATAWIDTH_BUS                  (8),
    .DATAWIDTH_DECODER_SELECTION    (3),
    .DATAWIDTH_MUX_SELECTION        (3),
    .DATAWIDTH_ALU_SELECTION        (4),
    .DATAWIDTH_REGSHIFTER_SELECTION (2),
    .FIX0_VALUE                     (8'h01),
    .FIX1_VALUE                     (8'h55)
  ) dut (
    .SC_STATEMACHINE_CLOCK_50     (clk),
    .SC_STATEMACHINE_Reset_InHigh (rst),
    .bus                          (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (flags kept active-high).
  logic [7:0] m_gen [4];
  logic [7:0] m_sh;
  bit m_ov, m_cy, m_neg, m_z;

  function automatic logic [7:0] m_read(input logic [2:0] sel);
    int s;
    s = sel;
    if (s < 4) return m_gen[s];
    if (s == 4) return 8'h01;
    if (s == 5) return 8'h55;
    return 8'h00;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_gen[i] = 8'h00;
    m_sh = 8'h00;
    m_ov = 0; m_cy = 0; m_neg = 0; m_z = 0;
  endtask

  // Apply one microinstruction for one clock edge and advance the model.
  task automatic cycle(input logic [2:0] dec, input logic [2:0] sa,
                       input logic [2:0] sb, input logic [3:0] op,
                       input logic ld_n, input logic [1:0] shs);
    logic [7:0] a, b, res;
    int ua, ub, sai, sbi, r, sr, opi, deci;
    bit c, v;
    bus.DecoderSelectionWrite_In       = dec;
    bus.MUXSelectionBUSA_In            = sa;
    bus.MUXSelectionBUSB_In            = sb;
    bus.ALUSelection_In                = op;
    bus.RegSHIFTERLoad_InLow           = ld_n;
    bus.RegSHIFTERShiftSelection_InLow = shs;
    a = m_read(sa); b = m_read(sb);
    ua = a; ub = b; opi = op; c = 0; v = 0; res = a; r = 0; sr = 0;
    case (opi)
      1: res = a | b;
      2: res = a & b;
      3: res = ~a;
      4: res = a ^ b;
      8, 9, 10, 11: begin
        if (opi >= 10) ub = 1;
        sai = (ua > 127) ? ua - 256 : ua;
        sbi = (ub > 127) ? ub - 256 : ub;
        if (opi == 8 || opi == 10) begin
          r = ua + ub; c = (r > 255); sr = sai + sbi;
        end else begin
          r = ua - ub; c = (ua < ub); sr = sai - sbi;
        end
        v = (sr > 127) || (sr < -128);
        res = r[7:0];
      end
      default: res = a;
    endcase
    deci = dec;
    if (deci < 4) m_gen[deci] = m_sh;
    if (!ld_n) begin
      m_sh = res;
      m_ov = v; m_cy = c; m_neg = res[7]; m_z = (res == 8'h00);
    end else if (shs == 2'b01) begin
`ifdef SC_DATAPATH_SHIFT_CARRY_EN
      m_cy = (m_sh >= 128);
`endif
      m_sh = 8'((m_sh * 2) % 256);
    end else if (shs == 2'b10) begin
`ifdef SC_DATAPATH_SHIFT_CARRY_EN
      m_cy = (m_sh % 2) == 1;
`endif
      m_sh = m_sh / 2;
    end
    @(posedge clk);
    #1;
  endtask

  // Build an arbitrary value in GENn using only datapath operations.
  task automatic set_gen(input int idx, input logic [7:0] val);
    logic [2:0] g;
    g = 3'(idx);
    cycle(DEC_NOWRITE, SEL_ZERO, SEL_ZERO, ALU_PASS, 1'b0, SHIFT_HOLD);
    cycle(g, SEL_ZERO, SEL_ZERO, ALU_PASS, 1'b1, SHIFT_HOLD);
    for (int k = 7; k >= 0; k--) begin
      cycle(DEC_NOWRITE, g, SEL_ZERO, ALU_PASS, 1'b0, SHIFT_HOLD);
      cycle(DEC_NOWRITE, g, SEL_ZERO, ALU_PASS, 1'b1, SHIFT_LEFT);
      cycle(g, g, SEL_ZERO, ALU_PASS, 1'b1, SHIFT_HOLD);
      if (val[k]) begin
        cycle(DEC_NOWRITE, g, SEL_FIX0, ALU_ADD, 1'b0, SHIFT_HOLD);
        cycle(g, g, SEL_ZERO, ALU_PASS, 1'b1, SHIFT_HOLD);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_dbg [6];
    exp_dbg[0] = 8'h00; exp_dbg[1] = 8'h00; exp_dbg[2] = 8'h00;
    exp_dbg[3] = 8'h00; exp_dbg[4] = 8'h01; exp_dbg[5] = 8'h55;
    // Dirty the state first, then reset away from a clock edge.
    cycle(DEC_NOWRITE, SEL_FIX1, SEL_ZERO, ALU_PASS, 1'b0, SHIFT_HOLD);
    cycle(3'd1, SEL_FIX0, SEL_ZERO, ALU_DEC, 1'b0, SHIFT_HOLD);
    cycle(3'd0, SEL_ZERO, SEL_ZERO, ALU_PASS, 1'b1, SHIFT_HOLD);
    #4;
    bus.DecoderSelectionWrite_In = 3'd2;
    rst = 1'b1;
    m_reset();
    #1;
    checks++;
    if (bus.BUSC_Out !== 8'h00) begin
      errors++; $display("FAIL reset_busc: got %h expected 00", bus.BUSC_Out);
    end
    checks++;
    if ({bus.Overflow_OutLow, bus.Carry_OutLow, bus.Negative_OutLow, bus.Zero_OutLow} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 1111",
               {bus.Overflow_OutLow, bus.Carry_OutLow, bus.Negative_OutLow, bus.Zero_OutLow});
    end
    // Hold reset across an edge with a write requested: nothing may land.
    @(posedge clk);
    #2;
    for (int s = 0; s < 6; s++) begin
      bus.DebugSelect_In = 3'(s);
      #1;
      checks++;
      if (bus.DebugData_Out !== exp_dbg[s]) begin
        errors++;
        $display("FAIL reset_debug_sel%0d: got %h expected %h", s, bus.DebugData_Out, exp_dbg[s]);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_shift_into_gen2();
    cycle(DEC_NOWRITE, SEL_FIX1, SEL_ZERO, ALU_PASS, 1'b0, SHIFT_HOLD);
    checks++;
    if (bus.BUSC_Out !== 8'h55) begin
      errors++; $display("FAIL gen2_load_busc: got %h expected 55", bus.BUSC_Out);
    end
    checks++;
    if ({bus.Negative_OutLow, bus.Zero_OutLow} !== 2'b11) begin
      errors++; $display("FAIL gen2_load_flags: got N/Z %b expected 11",
                         {bus.Negative_OutLow, bus.Zero_OutLow});
    end
    cycle(DEC_NOWRITE, SEL_ZERO, SEL_ZERO, ALU_PASS, 1'b1, SHIFT_LEFT);
    checks++;
    if (bus.BUSC_Out !== 8'hAA) begin
      errors++; $display("FAIL gen2_shift_busc: got %h expected aa", bus.BUSC_Out);
    end
    cycle(3'd2, SEL_ZERO, SEL_ZERO, ALU_PASS, 1'b1, SHIFT_HOLD);
    bus.DebugSelect_In = SEL_GEN2;
    #1;
    checks++;
    if (bus.DebugData_Out !== 8'hAA) begin
      errors++; $display("FAIL gen2_written: got %h expected aa", bus.DebugData_Out);
    end
  endtask

  task automatic test_add_overflow();
    set_gen(0, 8'h7F);
    set_gen(1, 8'h01);
    cycle(DEC_NOWRITE, SEL_GEN0, SEL_GEN1, ALU_ADD, 1'b0, SHIFT_HOLD);
    checks++;
    if (bus.BUSC_Out !== 8'h80) begin
      errors++; $display("FAIL add_result: got %h expected 80", bus.BUSC_Out);
    end
    checks++;
    if ({bus.Overflow_OutLow, bus.Carry_OutLow, bus.Negative_OutLow, bus.Zero_OutLow} !== 4'b0101) begin
      errors++;
      $display("FAIL add_flags: got V/C/N/Z %b expected 0101",
               {bus.Overflow_OutLow, bus.Carry_OutLow, bus.Negative_OutLow, bus.Zero_OutLow});
    end
  endtask

  task automatic test_sub();
    set_gen(0, 8'h33);
    set_gen(1, 8'h33);
    cycle(DEC_NOWRITE, SEL_GEN0, SEL_GEN1, ALU_SUB, 1'b0, SHIFT_HOLD);
    checks++;
    if ({bus.Carry_OutLow, bus.Zero_OutLow} !== 2'b10) begin
      errors++; $display("FAIL sub_zero_flags: got C/Z %b expected 10",
                         {bus.Carry_OutLow, bus.Zero_OutLow});
    end
    set_gen(0, 8'h01);
    set_gen(1, 8'h02);
    cycle(DEC_NOWRITE, SEL_GEN0, SEL_GEN1, ALU_SUB, 1'b0, SHIFT_HOLD);
    checks++;
    if (bus.BUSC_Out !== 8'hFF) begin
      errors++; $display("FAIL sub_borrow_result: got %h expected ff", bus.BUSC_Out);
    end
    checks++;
    if ({bus.Carry_OutLow, bus.Negative_OutLow} !== 2'b00) begin
      errors++; $display("FAIL sub_borrow_flags: got C/N %b expected 00",
                         {bus.Carry_OutLow, bus.Negative_OutLow});
    end
  endtask

  task automatic test_priority();
    cycle(DEC_NOWRITE, SEL_FIX0, SEL_ZERO, ALU_PASS, 1'b0, SHIFT_LEFT);
    checks++;
    if (bus.BUSC_Out !== 8'h01) begin
      errors++; $display("FAIL load_over_shift: got %h expected 01", bus.BUSC_Out);
    end
    cycle(3'd3, SEL_FIX1, SEL_ZERO, ALU_PASS, 1'b0, SHIFT_HOLD);
    bus.DebugSelect_In = SEL_GEN3;
    #1;
    checks++;
    if (bus.DebugData_Out !== 8'h01) begin
      errors++; $display("FAIL write_old_busc: got %h expected 01", bus.DebugData_Out);
    end
    checks++;
    if (bus.BUSC_Out !== 8'h55) begin
      errors++; $display("FAIL write_and_load_busc: got %h expected 55", bus.BUSC_Out);
    end
    cycle(DEC_NOWRITE, 3'b110, SEL_ZERO, ALU_PASS, 1'b0, SHIFT_HOLD);
    checks++;
    if (bus.BUSC_Out !== 8'h00) begin
      errors++; $display("FAIL mux110_zero: got %h expected 00", bus.BUSC_Out);
    end
    cycle(DEC_NOWRITE, 3'b111, SEL_FIX1, ALU_OR, 1'b0, SHIFT_HOLD);
    checks++;
    if (bus.BUSC_Out !== 8'h55) begin
      errors++; $display("FAIL mux111_zero: got %h expected 55", bus.BUSC_Out);
    end
  endtask

  task automatic test_shift_flags();
    logic z_before;
    cycle(DEC_NOWRITE, SEL_FIX0, SEL_ZERO, ALU_PASS, 1'b0, SHIFT_HOLD);
    for (int k = 0; k < 7; k++)
      cycle(DEC_NOWRITE, SEL_ZERO, SEL_ZERO, ALU_PASS, 1'b1, SHIFT_LEFT);
    checks++;
    if (bus.BUSC_Out !== 8'h80) begin
      errors++; $display("FAIL shift_to_80: got %h expected 80", bus.BUSC_Out);
    end
    z_before = ~m_z;
    cycle(DEC_NOWRITE, SEL_ZERO, SEL_ZERO, ALU_PASS, 1'b1, SHIFT_LEFT);
    checks++;
    if (bus.BUSC_Out !== 8'h00) begin
      errors++; $display("FAIL shift_out_msb: got %h expected 00", bus.BUSC_Out);
    end
`ifdef SC_DATAPATH_SHIFT_CARRY_EN
    checks++;
    if (bus.Carry_OutLow !== 1'b0) begin
      errors++; $display("FAIL shift_carry: got %b expected 0", bus.Carry_OutLow);
    end
`else
    checks++;
    if (bus.Carry_OutLow !== 1'b1) begin
      errors++; $display("FAIL shift_no_carry: got %b expected 1", bus.Carry_OutLow);
    end
`endif
    checks++;
    if (bus.Zero_OutLow !== z_before) begin
      errors++; $display("FAIL shift_zero_hold: got %b expected %b", bus.Zero_OutLow, z_before);
    end
  endtask

  task automatic test_random();
    logic [2:0] dec, sa, sb, dsel;
    logic [3:0] op, exp_flags;
    logic ld_n;
    logic [1:0] shs;
    for (int n = 0; n < 300; n++) begin
      dec  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      sa   = 3'($urandom_range(0, 7));
      sb   = 3'($urandom_range(0, 7));
      op   = 4'($urandom_range(0, 15));
      ld_n = ($urandom_range(0, 1) == 0);
      shs  = 2'($urandom_range(0, 3));
      cycle(dec, sa, sb, op, ld_n, shs);
      checks++;
      if (bus.BUSC_Out !== m_sh) begin
        errors++; $display("FAIL rand_busc[%0d]: got %h expected %h", n, bus.BUSC_Out, m_sh);
      end
      exp_flags = ~{m_ov, m_cy, m_neg, m_z};
      checks++;
      if ({bus.Overflow_OutLow, bus.Carry_OutLow, bus.Negative_OutLow, bus.Zero_OutLow} !== exp_flags) begin
        errors++;
        $display("FAIL rand_flags[%0d]: got %b expected %b", n,
                 {bus.Overflow_OutLow, bus.Carry_OutLow, bus.Negative_OutLow, bus.Zero_OutLow},
                 exp_flags);
      end
      dsel = 3'($urandom_range(0, 7));
      bus.DebugSelect_In = dsel;
      #1;
      checks++;
      if (bus.DebugData_Out !== m_read(dsel)) begin
        errors++; $display("FAIL rand_debug[%0d] sel %0d: got %h expected %h", n, dsel,
                           bus.DebugData_Out, m_read(dsel));
      end
    end
  endtask

  initial begin
    bus.DecoderSelectionWrite_In       = DEC_NOWRITE;
    bus.MUXSelectionBUSA_In            = SEL_ZERO;
    bus.MUXSelectionBUSB_In            = SEL_ZERO;
    bus.ALUSelection_In                = ALU_PASS;
    bus.RegSHIFTERLoad_InLow           = 1'b1;
    bus.RegSHIFTERShiftSelection_InLow = SHIFT_HOLD;
    bus.DebugSelect_In                 = SEL_FIX1;
    m_reset();
    #25;
    checks++;
    if ({bus.BUSC_Out, bus.Overflow_OutLow, bus.Carry_OutLow, bus.Negative_OutLow, bus.Zero_OutLow}
        !== {8'h00, 4'b1111}) begin
      errors++; $display("FAIL powerup_state: got busc %h flags %b expected 00 1111", bus.BUSC_Out,
                         {bus.Overflow_OutLow, bus.Carry_OutLow, bus.Negative_OutLow, bus.Zero_OutLow});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_shift_into_gen2();
    test_add_overflow();
    test_sub();
    test_priority();
    test_shift_flags();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
